// File: rtl/imm_gen_pipe.sv
// Immediate decode/extend pipeline stage.
// Decodes the opcode into an immediate-format code, builds the XLEN-wide
// extended immediate and flags unknown opcodes. Decoded results sit in one
// output register backed by a one-entry skid register. This keeps full
// throughput under backpressure while in_ready stays a pure register output.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter bit CSR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_imm_src,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  // Immediate format codes
  localparam logic [2:0] SRC_I    = 3'b000;
  localparam logic [2:0] SRC_S    = 3'b001;
  localparam logic [2:0] SRC_B    = 3'b010;
  localparam logic [2:0] SRC_J    = 3'b011;
  localparam logic [2:0] SRC_U    = 3'b100;
  localparam logic [2:0] SRC_Z    = 3'b101;
  localparam logic [2:0] SRC_NONE = 3'b111;

  // Opcodes of interest
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_SYSTEM = 7'd115;

  // Decode results for the instruction currently presented
  logic [6:0]      w_opcode;
  logic [2:0]      w_src;
  logic [31:0]     w_imm32;
  logic            w_is_z;
  logic            w_ill;
  logic [XLEN-1:0] w_imm;

  // Handshake helpers
  logic w_accept;
  logic w_out_load;

  // Output register
  logic            r_out_valid;
  logic [2:0]      r_out_src;
  logic [XLEN-1:0] r_out_imm;
  logic            r_out_ill;

  // Skid register
  logic            r_skid_valid;
  logic [2:0]      r_skid_src;
  logic [XLEN-1:0] r_skid_imm;
  logic            r_skid_ill;

  assign w_opcode = in_instr[6:0];

  // Opcode to format decode; the 32-bit immediate is later sign-extended to XLEN
  always_comb begin
    w_src   = SRC_NONE;
    w_imm32 = '0;
    w_is_z  = 1'b0;
    w_ill   = 1'b0;
    case (w_opcode)
      OP_LOAD, OP_IMM, OP_JALR: begin
        w_src   = SRC_I;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        w_src   = SRC_S;
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        w_src   = SRC_B;
        w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        w_src   = SRC_J;
        w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_AUIPC, OP_LUI: begin
        w_src   = SRC_U;
        w_imm32 = {in_instr[31:12], 12'b0};
      end
      OP_REG: begin
        w_src = SRC_NONE;
      end
      OP_SYSTEM: begin
        if (in_instr[14]) begin
          // CSR immediate forms carry a 5-bit unsigned zimm in rs1
          if (CSR_EN) begin
            w_src  = SRC_Z;
            w_is_z = 1'b1;
          end else begin
            w_ill = 1'b1;
          end
        end else begin
          // CSR register forms and ecall/ebreak: the CSR address field as I-imm
          w_src   = SRC_I;
          w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase
  end

  assign w_imm = w_is_z ? XLEN'(in_instr[19:15]) : XLEN'($signed(w_imm32));

  // Skid must be empty to accept, so in_ready never depends on out_ready
  assign in_ready   = !r_skid_valid;
  assign w_accept   = in_valid && !r_skid_valid;
  assign w_out_load = !r_out_valid || out_ready;

  // Output register: refill from skid first to preserve order, else from input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_src   <= SRC_NONE;
      r_out_imm   <= '0;
      r_out_ill   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_src   <= SRC_NONE;
      r_out_imm   <= '0;
      r_out_ill   <= 1'b0;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out_valid <= 1'b1;
        r_out_src   <= r_skid_src;
        r_out_imm   <= r_skid_imm;
        r_out_ill   <= r_skid_ill;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_src   <= w_src;
        r_out_imm   <= w_imm;
        r_out_ill   <= w_ill;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Skid register: captures an accepted entry only while the output is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid_src   <= SRC_NONE;
      r_skid_imm   <= '0;
      r_skid_ill   <= 1'b0;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
    end else if (w_out_load) begin
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_src   <= w_src;
      r_skid_imm   <= w_imm;
      r_skid_ill   <= w_ill;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_imm_src = r_out_src;
  assign out_imm     = r_out_imm;
  assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: a 32-bit CSR-enabled instance and a
// 64-bit CSR-disabled instance share the same stimulus and handshakes.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [2:0]  src;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [2:0]  out_imm_src;
  logic [31:0] out_imm;
  logic        out_illegal;

  logic        in_ready_64;
  logic        out_valid_64;
  logic [2:0]  out_imm_src_64;
  logic [63:0] out_imm_64;
  logic        out_illegal_64;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];

  imm_gen_pipe #(.XLEN(32), .CSR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm_src(out_imm_src), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(64), .CSR_EN(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_64), .in_instr(in_instr),
    .out_valid(out_valid_64), .out_ready(out_ready),
    .out_imm_src(out_imm_src_64), .out_imm(out_imm_64), .out_illegal(out_illegal_64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written from the instruction-format definitions
  function automatic exp_t model(input logic [31:0] ins, input bit csr);
    exp_t e;
    logic [11:0] i12;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e.src = 3'b111;
    e.imm = 64'd0;
    e.ill = 1'b0;
    case (ins[6:0])
      7'd3, 7'd19, 7'd103: begin e.src = 3'd0; e.imm = {{52{i12[11]}}, i12}; end
      7'd35:  begin e.src = 3'd1; e.imm = {{52{s12[11]}}, s12}; end
      7'd99:  begin e.src = 3'd2; e.imm = {{51{b13[12]}}, b13}; end
      7'd111: begin e.src = 3'd3; e.imm = {{43{j21[20]}}, j21}; end
      7'd23, 7'd55: begin e.src = 3'd4; e.imm = {{32{ins[31]}}, ins[31:12], 12'h000}; end
      7'd51:  e.src = 3'b111;
      7'd115: begin
        if (!ins[14]) begin
          e.src = 3'd0;
          e.imm = {{52{i12[11]}}, i12};
        end else if (csr) begin
          e.src = 3'd5;
          e.imm = {59'd0, ins[19:15]};
        end else begin
          e.ill = 1'b1;
        end
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes that happen at the coming edge, then advance
  task automatic tick();
    exp_t e32;
    exp_t e64;
    logic [31:0] ins;
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          ins = sb.pop_front();
          e32 = model(ins, 1'b1);
          e64 = model(ins, 1'b0);
          $display("xfer instr=%h src=%0d imm=%h ill=%0b | x64 src=%0d imm=%h ill=%0b",
                   ins, out_imm_src, out_imm, out_illegal,
                   out_imm_src_64, out_imm_64, out_illegal_64);
          chk("src32", 64'(out_imm_src), 64'(e32.src));
          chk("imm32", 64'(out_imm), 64'(e32.imm[31:0]));
          chk("ill32", 64'(out_illegal), 64'(e32.ill));
          chk("valid64", 64'(out_valid_64), 64'd1);
          chk("src64", 64'(out_imm_src_64), 64'(e64.src));
          chk("imm64", out_imm_64, e64.imm);
          chk("ill64", 64'(out_illegal_64), 64'(e64.ill));
        end
      end
      if (in_valid && in_ready) sb.push_back(in_instr);
    end
    @(posedge clk);
    #1;
  endtask

  // Single instruction with out_ready=1: visible the cycle after acceptance
  task automatic send1(input logic [31:0] ins, input logic [2:0] src,
                       input logic [31:0] imm, input logic ill);
    in_valid = 1'b1;
    in_instr = ins;
    tick();
    in_valid = 1'b0;
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("dir_src", 64'(out_imm_src), 64'(src));
    chk("dir_imm", 64'(out_imm), 64'(imm));
    chk("dir_ill", 64'(out_illegal), 64'(ill));
    tick();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_valid64"}, 64'(out_valid_64), 64'd0);
  endtask

  logic [6:0] ops [12] = '{7'd3, 7'd19, 7'd103, 7'd35, 7'd99, 7'd111,
                           7'd23, 7'd55, 7'd51, 7'd115, 7'd127, 7'd0};

  initial begin
    logic [31:0] r;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check_idle("rst");
    chk("rst_src", 64'(out_imm_src), 64'd7);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_ill", 64'(out_illegal), 64'd0);
    chk("rst_imm64", out_imm_64, 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed formats
    in_valid = 1'b1;
    in_instr = 32'hFFF00093;
    tick();
    in_valid = 1'b0;
    chk("addi_imm64", out_imm_64, 64'hFFFFFFFFFFFFFFFF);
    tick();
    send1(32'hFFF00093, 3'd0, 32'hFFFFFFFF, 1'b0);
    send1(32'h00112623, 3'd1, 32'h0000000C, 1'b0);
    send1(32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 1'b0);
    send1(32'h123450B7, 3'd4, 32'h12345000, 1'b0);
    send1(32'h3002D073, 3'd5, 32'h00000005, 1'b0);
    send1(32'h0000007F, 3'd7, 32'h00000000, 1'b1);
    send1(32'h002081B3, 3'd7, 32'h00000000, 1'b0);
    send1(32'h0080006F, 3'd3, 32'h00000008, 1'b0);
    send1(32'h00000073, 3'd0, 32'h00000000, 1'b0);

    // Back-to-back stream at full rate
    for (int i = 0; i < 12; i++) begin
      r = $urandom();
      r[6:0] = ops[i];
      in_valid = 1'b1;
      in_instr = r;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Backpressure: A at output, B in skid, C stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    tick();
    in_instr  = 32'h00112623;
    tick();
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    in_instr  = 32'h123450B7;
    tick();
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("bp_c_stalled", 64'(sb.size()), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_b_imm", 64'(out_imm), 64'h0000000C);
    tick();
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    chk("bp_c_imm", 64'(out_imm), 64'h12345000);
    in_valid = 1'b0;
    tick();
    chk("bp_done_valid", 64'(out_valid), 64'd0);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with A at output and B in skid; D presented with flush is dropped
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFF00093;
    tick();
    in_instr  = 32'h00112623;
    tick();
    in_instr  = 32'h0080006F;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check_idle("flush");
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_nothing", 64'(out_valid), 64'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFE000EE3;
    tick();
    in_instr  = 32'h3002D073;
    tick();
    rst_n = 1'b0;
    tick();
    in_valid = 1'b0;
    check_idle("mrst");
    chk("mrst_src", 64'(out_imm_src), 64'd7);
    chk("mrst_imm", 64'(out_imm), 64'd0);
    chk("mrst_ill", 64'(out_illegal), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Random traffic with random backpressure
    for (int i = 0; i < 200; i++) begin
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 11)];
      in_valid  = 1'($urandom_range(0, 1));
      in_instr  = r;
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    tick();
    chk("rand_sb_empty", 64'(sb.size()), 64'd0);
    chk("rand_idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
